// File: rtl/i2c_av_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller between a boot-time config port (A) and a
// runtime write port (B), with NACK/timeout retry, post-attempt bus recovery gap and error count.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | no owner; pick a requester (round-robin on contention)
// ISSUE    | raise GO for the captured frame, arm the timeout counter
// WAIT_END | GO high, waiting for END or timeout
// END_LOW  | attempt finished, waiting for the controller to drop END
// GAP      | enforced idle after every attempt; decide retry or respond
// RESP     | one-cycle DONE/ERR to the owner, update round-robin pointer

module i2c_av_arbiter #(
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int GAP_CYC     = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iA_REQ,
    input  logic [23:0] iA_DATA,
    output logic        oA_DONE,
    output logic        oA_ERR,
    input  logic        iB_REQ,
    input  logic [23:0] iB_DATA,
    output logic        oB_DONE,
    output logic        oB_ERR,
    output logic [23:0] oI2C_DATA,
    output logic        oI2C_GO,
    input  logic        iI2C_END,
    input  logic        iI2C_ACK,
    output logic        oBUSY,
    output logic [7:0]  oERR_CNT
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
    localparam int AW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
    localparam logic [AW-1:0] ATT_LAST = AW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_END,
        S_END_LOW,
        S_GAP,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic [AW-1:0] attempt;
    logic          owner_b;
    logic          last_b;
    logic          fail;
    logic          grant_a;
    logic          grant_b;
    logic          tmo_tc;
    logic          gap_tc;
    logic          last_try;
    logic          finish;

    assign tmo_tc   = (tmo_cnt == '0);
    assign gap_tc   = (gap_cnt == '0);
    assign last_try = (attempt == ATT_LAST);
    assign finish   = !fail || last_try;
    assign oBUSY    = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        case (state)
            S_IDLE: begin
                // on contention the port not served last wins; last_b resets high so A goes first
                if (iA_REQ && (!iB_REQ || last_b)) begin
                    grant_a = 1'b1;
                end else if (iB_REQ) begin
                    grant_b = 1'b1;
                end
                if (grant_a || grant_b) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (iI2C_END) begin
                    state_nxt = S_END_LOW;
                end else if (tmo_tc) begin
                    state_nxt = S_GAP;
                end
            end
            S_END_LOW: begin
                if (!iI2C_END) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_tc) begin
                    state_nxt = finish ? S_RESP : S_ISSUE;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            attempt   <= '0;
            owner_b   <= 1'b0;
            last_b    <= 1'b1;
            fail      <= 1'b0;
            oA_DONE   <= 1'b0;
            oA_ERR    <= 1'b0;
            oB_DONE   <= 1'b0;
            oB_ERR    <= 1'b0;
            oI2C_DATA <= '0;
            oI2C_GO   <= 1'b0;
            oERR_CNT  <= '0;
        end else begin
            state   <= state_nxt;
            oA_DONE <= 1'b0;
            oA_ERR  <= 1'b0;
            oB_DONE <= 1'b0;
            oB_ERR  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_a || grant_b) begin
                        oI2C_DATA <= grant_b ? iB_DATA : iA_DATA;
                        owner_b   <= grant_b;
                        attempt   <= '0;
                        fail      <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    oI2C_GO <= 1'b1;
                    tmo_cnt <= TMO_LOAD;
                end
                S_WAIT_END: begin
                    if (iI2C_END) begin
                        oI2C_GO <= 1'b0;
                        fail    <= iI2C_ACK;
                        gap_cnt <= GAP_LOAD;
                    end else if (tmo_tc) begin
                        oI2C_GO <= 1'b0;
                        fail    <= 1'b1;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_tc) begin
                        if (fail && (oERR_CNT != 8'hFF)) begin
                            oERR_CNT <= oERR_CNT + 8'd1;
                        end
                        // DONE/ERR are registered here so they are high during the RESP cycle
                        if (finish) begin
                            oA_DONE <= !owner_b;
                            oA_ERR  <= !owner_b && fail;
                            oB_DONE <= owner_b;
                            oB_ERR  <= owner_b && fail;
                        end else begin
                            attempt <= attempt + 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    last_b <= owner_b;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_av_arbiter.sv
// Directed bench for i2c_av_arbiter: behavioural I2C_Controller model plus one task per scenario.
module tb_i2c_av_arbiter;

    localparam int MAX_RETRY   = 3;
    localparam int TIMEOUT_CYC = 1000;
    localparam int GAP_CYC     = 8;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iA_REQ = 1'b0;
    logic [23:0] iA_DATA = '0;
    logic        iB_REQ = 1'b0;
    logic [23:0] iB_DATA = '0;
    logic        iI2C_END = 1'b0;
    logic        iI2C_ACK = 1'b0;
    logic        oA_DONE, oA_ERR, oB_DONE, oB_ERR, oI2C_GO, oBUSY;
    logic [23:0] oI2C_DATA;
    logic [7:0]  oERR_CNT;

    int checks = 0;
    int passes = 0;

    // controller model knobs
    bit hang = 1'b0;
    int end_delay = 3;
    int nack_n = 0;
    int go_base = 0;
    int go_total = 0;

    i2c_av_arbiter #(
        .MAX_RETRY  (MAX_RETRY),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .GAP_CYC    (GAP_CYC)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iA_REQ   (iA_REQ),
        .iA_DATA  (iA_DATA),
        .oA_DONE  (oA_DONE),
        .oA_ERR   (oA_ERR),
        .iB_REQ   (iB_REQ),
        .iB_DATA  (iB_DATA),
        .oB_DONE  (oB_DONE),
        .oB_ERR   (oB_ERR),
        .oI2C_DATA(oI2C_DATA),
        .oI2C_GO  (oI2C_GO),
        .iI2C_END (iI2C_END),
        .iI2C_ACK (iI2C_ACK),
        .oBUSY    (oBUSY),
        .oERR_CNT (oERR_CNT)
    );

    always #5 iCLK = ~iCLK;

    // Controller: END after end_delay cycles, NACK for the first nack_n attempts after go_base,
    // holds END until GO drops, then releases END one cycle later. In hang mode END never rises.
    initial begin
        forever begin
            @(posedge iCLK iff oI2C_GO);
            go_total = go_total + 1;
            if (hang) begin
                while (oI2C_GO) @(negedge iCLK);
            end else begin
                repeat (end_delay) @(negedge iCLK);
                iI2C_END = 1'b1;
                iI2C_ACK = ((go_total - go_base) <= nack_n);
                while (oI2C_GO) @(negedge iCLK);
                @(negedge iCLK);
                iI2C_END = 1'b0;
                iI2C_ACK = 1'b0;
            end
        end
    end

    task automatic reset_dut();
        @(negedge iCLK);
        iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
    endtask

    // Bounded wait for a DONE pulse; also profiles the GO waveform seen meanwhile.
    task automatic wait_done(input int budget, output bit got_b, output bit err,
                             output int pulses, output int min_gap, output int max_high);
        int  low_run;
        int  high_run;
        bit  prev;
        bit  seen;
        got_b = 1'b0; err = 1'b0; pulses = 0; min_gap = 1 << 30; max_high = 0;
        low_run = 0; high_run = 0; prev = oI2C_GO; seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge iCLK);
            if (oI2C_GO) begin
                if (!prev) begin
                    pulses++;
                    if (pulses > 1 && low_run < min_gap) min_gap = low_run;
                    high_run = 0;
                end
                high_run++;
                if (high_run > max_high) max_high = high_run;
            end else begin
                if (prev) low_run = 0;
                low_run++;
            end
            prev = oI2C_GO;
            if (oA_DONE || oB_DONE) begin
                seen  = 1'b1;
                got_b = oB_DONE;
                err   = oB_DONE ? oB_ERR : oA_ERR;
                checks++;
                if (oA_DONE && oB_DONE)
                    $display("FAIL dual_done: got A=1 B=1 required a single DONE");
                else
                    passes++;
                break;
            end
        end
        checks++;
        if (!seen) $display("FAIL done_timeout: got no DONE in %0d cycles required one", budget);
        else passes++;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        repeat (2) @(negedge iCLK);
        checks++;
        if ({oA_DONE, oA_ERR, oB_DONE, oB_ERR, oI2C_GO, oBUSY, oI2C_DATA, oERR_CNT} !== '0)
            $display("FAIL reset_outputs: got %b required all zero",
                     {oA_DONE, oA_ERR, oB_DONE, oB_ERR, oI2C_GO, oBUSY, oI2C_DATA, oERR_CNT});
        else passes++;
        iRST = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic test_single_a();
        bit got_b, err;
        int pulses, min_gap, max_high;
        hang = 1'b0; end_delay = 100; nack_n = 0; go_base = go_total;
        iA_DATA = 24'h34_1A_5C;
        iA_REQ  = 1'b1;
        wait_done(500, got_b, err, pulses, min_gap, max_high);
        iA_REQ = 1'b0;
        checks++;
        if (got_b !== 1'b0) $display("FAIL single_owner: got B=%0b required A", got_b);
        else passes++;
        checks++;
        if (err !== 1'b0) $display("FAIL single_err: got %0b required 0", err);
        else passes++;
        checks++;
        if (pulses !== 1) $display("FAIL single_go_pulses: got %0d required 1", pulses);
        else passes++;
        checks++;
        if (oI2C_DATA !== 24'h34_1A_5C) $display("FAIL single_data: got %h required 341a5c", oI2C_DATA);
        else passes++;
        checks++;
        if (oERR_CNT !== 8'd0) $display("FAIL single_errcnt: got %0d required 0", oERR_CNT);
        else passes++;
        @(negedge iCLK);
        checks++;
        if ({oA_DONE, oBUSY} !== 2'b00) $display("FAIL single_after_resp: got done,busy=%b required 00", {oA_DONE, oBUSY});
        else passes++;
    endtask

    task automatic serve_single(input bit use_b);
        bit got_b, err;
        int pulses, min_gap, max_high;
        if (use_b) iB_REQ = 1'b1; else iA_REQ = 1'b1;
        wait_done(500, got_b, err, pulses, min_gap, max_high);
        iA_REQ = 1'b0; iB_REQ = 1'b0;
        checks++;
        if (got_b !== use_b) $display("FAIL rr_single_owner: got B=%0b required B=%0b", got_b, use_b);
        else passes++;
    endtask

    task automatic serve_pair(input bit b_first, input int idx);
        bit got_b, err;
        int pulses, min_gap, max_high;
        iA_REQ = 1'b1; iB_REQ = 1'b1;
        wait_done(500, got_b, err, pulses, min_gap, max_high);
        checks++;
        if (got_b !== b_first || err !== 1'b0 || oI2C_DATA !== (b_first ? iB_DATA : iA_DATA))
            $display("FAIL rr_pair%0d_first: got B=%0b err=%0b data=%h required B=%0b err=0",
                     idx, got_b, err, oI2C_DATA, b_first);
        else passes++;
        if (got_b) iB_REQ = 1'b0; else iA_REQ = 1'b0;
        wait_done(500, got_b, err, pulses, min_gap, max_high);
        checks++;
        if (got_b !== !b_first || err !== 1'b0 || oI2C_DATA !== (b_first ? iA_DATA : iB_DATA))
            $display("FAIL rr_pair%0d_second: got B=%0b err=%0b data=%h required B=%0b err=0",
                     idx, got_b, err, oI2C_DATA, !b_first);
        else passes++;
        iA_REQ = 1'b0; iB_REQ = 1'b0;
    endtask

    task automatic test_round_robin();
        hang = 1'b0; end_delay = 5; nack_n = 0;
        iA_DATA = 24'h34_0C_01;
        iB_DATA = 24'h40_05_7F;
        reset_dut();
        serve_pair(1'b0, 1);   // after reset A has priority
        serve_single(1'b0);    // A served last
        serve_pair(1'b1, 2);   // ends with A served last
        serve_pair(1'b1, 3);
        serve_single(1'b1);    // B served last
        serve_pair(1'b0, 4);
    endtask

    task automatic test_nack_retry();
        bit got_b, err;
        int pulses, min_gap, max_high;
        reset_dut();
        hang = 1'b0; end_delay = 3; nack_n = 1000; go_base = go_total;
        iB_DATA = 24'h34_08_1F;
        iB_REQ  = 1'b1;
        wait_done(1000, got_b, err, pulses, min_gap, max_high);
        iB_REQ = 1'b0;
        checks++;
        if (got_b !== 1'b1 || err !== 1'b1) $display("FAIL nack_done: got B=%0b err=%0b required B=1 err=1", got_b, err);
        else passes++;
        checks++;
        if (pulses !== MAX_RETRY + 1) $display("FAIL nack_pulses: got %0d required %0d", pulses, MAX_RETRY + 1);
        else passes++;
        // low time = 2 END_LOW cycles (model releases END a cycle late) + GAP + ISSUE
        checks++;
        if (min_gap !== GAP_CYC + 3) $display("FAIL nack_gap: got %0d required %0d", min_gap, GAP_CYC + 3);
        else passes++;
        checks++;
        if (oERR_CNT !== 8'd4) $display("FAIL nack_errcnt: got %0d required 4", oERR_CNT);
        else passes++;
    endtask

    task automatic test_timeout();
        bit got_b, err;
        int pulses, min_gap, max_high;
        logic [7:0] cnt0;
        reset_dut();
        hang = 1'b1;
        iA_DATA = 24'h34_12_01;
        iA_REQ  = 1'b1;
        wait_done(6000, got_b, err, pulses, min_gap, max_high);
        iA_REQ = 1'b0;
        checks++;
        if (got_b !== 1'b0 || err !== 1'b1) $display("FAIL tmo_done: got B=%0b err=%0b required A err=1", got_b, err);
        else passes++;
        checks++;
        if (pulses !== 4 || max_high !== TIMEOUT_CYC)
            $display("FAIL tmo_go: got pulses=%0d high=%0d required 4 and %0d", pulses, max_high, TIMEOUT_CYC);
        else passes++;
        checks++;
        if (min_gap !== GAP_CYC + 1) $display("FAIL tmo_gap: got %0d required %0d", min_gap, GAP_CYC + 1);
        else passes++;
        checks++;
        if (oERR_CNT !== 8'd4) $display("FAIL tmo_errcnt: got %0d required 4", oERR_CNT);
        else passes++;
        // NACK on first attempt, then ACK
        @(negedge iCLK);
        hang = 1'b0; end_delay = 4; nack_n = 1; go_base = go_total;
        cnt0 = oERR_CNT;
        iA_REQ = 1'b1;
        wait_done(1000, got_b, err, pulses, min_gap, max_high);
        iA_REQ = 1'b0;
        checks++;
        if (got_b !== 1'b0 || err !== 1'b0 || pulses !== 2)
            $display("FAIL retry_ok: got B=%0b err=%0b pulses=%0d required A err=0 pulses=2", got_b, err, pulses);
        else passes++;
        checks++;
        if (oERR_CNT !== cnt0 + 8'd1) $display("FAIL retry_errcnt: got %0d required %0d", oERR_CNT, cnt0 + 8'd1);
        else passes++;
    endtask

    task automatic test_reset_midflight();
        bit got_b, err, saw_done;
        int pulses, min_gap, max_high, n;
        reset_dut();
        hang = 1'b1; nack_n = 0; end_delay = 3;
        iA_DATA = 24'h34_0A_AA;
        iB_DATA = 24'h40_0B_BB;
        iA_REQ = 1'b1; iB_REQ = 1'b1;
        saw_done = 1'b0;
        n = 0;
        while (!oI2C_GO && n < 50) begin @(negedge iCLK); n++; end
        checks++;
        if (oI2C_GO !== 1'b1) $display("FAIL rst_mid_go_high: got %0b required 1", oI2C_GO);
        else passes++;
        repeat (5) @(negedge iCLK);
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        checks++;
        if ({oI2C_GO, oBUSY, oA_DONE, oB_DONE} !== 4'b0000)
            $display("FAIL rst_mid_outputs: got go,busy,doneA,doneB=%b required 0000", {oI2C_GO, oBUSY, oA_DONE, oB_DONE});
        else passes++;
        @(negedge iCLK);
        iRST = 1'b0;
        hang = 1'b0;
        checks++;
        if (oERR_CNT !== 8'd0) $display("FAIL rst_mid_errcnt: got %0d required 0", oERR_CNT);
        else passes++;
        wait_done(500, got_b, err, pulses, min_gap, max_high);
        iA_REQ = got_b ? iA_REQ : 1'b0;
        checks++;
        if (got_b !== 1'b0 || err !== 1'b0 || oI2C_DATA !== 24'h34_0A_AA)
            $display("FAIL rst_mid_a: got B=%0b err=%0b data=%h required A err=0 data=340aaa", got_b, err, oI2C_DATA);
        else passes++;
        wait_done(500, got_b, err, pulses, min_gap, max_high);
        iA_REQ = 1'b0; iB_REQ = 1'b0;
        checks++;
        if (got_b !== 1'b1 || err !== 1'b0 || oI2C_DATA !== 24'h40_0B_BB)
            $display("FAIL rst_mid_b: got B=%0b err=%0b data=%h required B err=0 data=400bbb", got_b, err, oI2C_DATA);
        else passes++;
    endtask

    task automatic test_errcnt_saturation();
        bit got_b, err;
        int pulses, min_gap, max_high;
        reset_dut();
        hang = 1'b0; end_delay = 2; nack_n = 1 << 20; go_base = go_total;
        iB_DATA = 24'h34_1E_00;
        for (int t = 1; t <= 65; t++) begin
            iB_REQ = 1'b1;
            wait_done(500, got_b, err, pulses, min_gap, max_high);
            iB_REQ = 1'b0;
            if (t == 63) begin
                checks++;
                if (oERR_CNT !== 8'd252) $display("FAIL sat_252: got %0d required 252", oERR_CNT);
                else passes++;
            end
            if (t == 64) begin
                checks++;
                if (oERR_CNT !== 8'd255) $display("FAIL sat_256: got %0d required 255", oERR_CNT);
                else passes++;
            end
        end
        checks++;
        if (oERR_CNT !== 8'd255) $display("FAIL sat_260: got %0d required 255", oERR_CNT);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_round_robin();
        test_nack_retry();
        test_timeout();
        test_reset_midflight();
        test_errcnt_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
